// File: rtl/msk_and_hpc2_sched.sv
// Round-robin front end for one shared pipelined HPC2 masked AND gadget.
// Optional build macro: MSK_SCHED_ZEROIZE_EN (clear share registers of idle stages).
module msk_and_hpc2_sched #(
  parameter int d    = 2,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*d-1:0]     req_a,
  input  logic [NREQ*d-1:0]     req_b,
  input  logic [d*(d-1)/2-1:0]  rnd_in,
  input  logic                  rnd_valid,
  output logic                  rnd_ready,
  output logic [d-1:0]          g_ina,
  output logic [d-1:0]          g_inb,
  output logic [d*(d-1)/2-1:0]  g_rnd,
  input  logic [d-1:0]          g_out,
  output logic                  resp_valid,
  output logic [IDW-1:0]        resp_id,
  output logic [d-1:0]          resp_out
);

  localparam int NRND = d*(d-1)/2;

  // Handshake: requester k transfers a pair of sharings in the cycle where
  // req_valid[k] & req_ready[k]; req_ready is a one-hot grant that is only
  // offered while fresh randomness is present, so every accepted operation
  // consumes exactly one rnd_in word (rnd_ready marks that consumption).
  // Responses carry no ready: resp_valid is a single-cycle pulse.

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            found;
  int              idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    if (rnd_valid && !rst) begin
      for (int i = 0; i < NREQ; i++) begin
        idx = (int'(ptr) + i) % NREQ;
        if (!found && req_valid[idx]) begin
          found       = 1'b1;
          gnt[idx]    = 1'b1;
          gnt_id      = IDW'(idx);
        end
      end
    end
  end

  logic hs;
  assign req_ready = gnt;
  assign hs        = |(req_valid & gnt);
  assign rnd_ready = hs;

  logic [d-1:0] sel_a;
  logic [d-1:0] sel_b;
  assign sel_a = req_a[int'(gnt_id)*d +: d];
  assign sel_b = req_b[int'(gnt_id)*d +: d];

  // Pipeline control: stage valids and the id travelling with them.
  logic           v1, v2, v3;
  logic [IDW-1:0] id1, id2, id3;
  logic [d-1:0]   a_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      resp_valid <= 1'b0;
      id1        <= '0;
      id2        <= '0;
      id3        <= '0;
      resp_id    <= '0;
    end else begin
      if (hs) begin
        ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
      end
      v1         <= hs;
      v2         <= v1;
      v3         <= v2;
      resp_valid <= v3;
      id1        <= gnt_id;
      id2        <= id1;
      id3        <= id2;
      if (v3) begin
        resp_id <= id3;
      end
    end
  end

  // Share datapath: each share moves through plain registers only, never
  // combined with another share inside this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_inb    <= '0;
      g_rnd    <= '0;
      a_hold   <= '0;
      g_ina    <= '0;
      resp_out <= '0;
    end else begin
`ifdef MSK_SCHED_ZEROIZE_EN
      g_inb    <= hs ? sel_b  : '0;
      g_rnd    <= hs ? rnd_in : NRND'(0);
      a_hold   <= hs ? sel_a  : '0;
      g_ina    <= v1 ? a_hold : '0;
      resp_out <= v3 ? g_out  : '0;
`else
      if (hs) begin
        g_inb  <= sel_b;
        g_rnd  <= rnd_in;
        a_hold <= sel_a;
      end
      if (v1) begin
        g_ina <= a_hold;
      end
      if (v3) begin
        resp_out <= g_out;
      end
`endif
    end
  end

endmodule

// File: tb/tb_msk_and_hpc2_sched.sv
// Directed bench for msk_and_hpc2_sched (d=2, NREQ=4) with a behavioural
// first-order HPC2 AND gadget model (output two cycles after inb).
module tb_msk_and_hpc2_sched;

  localparam int D     = 2;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int NRND  = 1;
  localparam int EXP_W = IDW + 1;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*D-1:0] req_a;
  logic [NREQ*D-1:0] req_b;
  logic [NRND-1:0]   rnd_in;
  logic              rnd_valid;
  logic              rnd_ready;
  logic [D-1:0]      g_ina;
  logic [D-1:0]      g_inb;
  logic [NRND-1:0]   g_rnd;
  logic [D-1:0]      g_out;
  logic              resp_valid;
  logic [IDW-1:0]    resp_id;
  logic [D-1:0]      resp_out;

  msk_and_hpc2_sched #(.d(D), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .g_ina(g_ina), .g_inb(g_inb), .g_rnd(g_rnd), .g_out(g_out),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_out(resp_out)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gadget model: inb and rnd arrive one cycle before ina, out one cycle after ina
  logic [D-1:0]    inb_q;
  logic [NRND-1:0] rnd_q;
  always @(posedge clk) begin
    inb_q <= g_inb;
    rnd_q <= g_rnd;
    g_out <= {(g_ina[1] & inb_q[1]) ^ (g_ina[0] & inb_q[1]) ^ (g_ina[1] & inb_q[0]) ^ rnd_q[0],
              (g_ina[0] & inb_q[0]) ^ rnd_q[0]};
  end

`ifdef MSK_SCHED_ZEROIZE_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every response must match the oldest expected {id, a&b}
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        check("resp_unexp", 32'(resp_valid), 32'd0);
      end else begin
        logic [EXP_W-1:0] e;
        e = exp_q.pop_front();
        check("resp_id", 32'(resp_id), 32'(e[EXP_W-1:1]));
        check("resp_xor", 32'(resp_out[0] ^ resp_out[1]), 32'(e[0]));
      end
    end
  end

  initial begin
    logic [D-1:0] la, lb;
    int k;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rnd_in = '0; rnd_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rnd_ready", 32'(rnd_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_g_ina", 32'(g_ina), 32'd0);
    check("rst_g_inb", 32'(g_inb), 32'd0);
    check("rst_g_rnd", 32'(g_rnd), 32'd0);
    check("rst_resp_out", 32'(resp_out), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // single op from requester 2: a=10, b=11, rnd=1
    req_valid = 4'b0100; req_a = 8'b00_10_00_00; req_b = 8'b00_11_00_00;
    rnd_in = 1'b1; rnd_valid = 1'b1;
    @(negedge clk);
    check("t1_grant", 32'(req_ready), 32'h4);
    check("t1_rnd_ready", 32'(rnd_ready), 32'd1);
    exp_q.push_back({2'd2, 1'b0});
    tick();
    req_valid = '0; req_a = '0; req_b = '0; rnd_in = '0; rnd_valid = 1'b0;
    @(negedge clk);
    check("t1_g_inb", 32'(g_inb), 32'h3);
    check("t1_g_rnd", 32'(g_rnd), 32'd1);
    tick();
    @(negedge clk);
    check("t1_g_ina", 32'(g_ina), 32'h2);
    check("t1_g_inb_after", 32'(g_inb), ZERO ? 32'd0 : 32'h3);
    tick();
    @(negedge clk);
    check("t1_no_early_resp", 32'(resp_valid), 32'd0);
    check("t1_g_ina_after", 32'(g_ina), ZERO ? 32'd0 : 32'h2);
    tick();
    @(negedge clk);
    check("t1_resp_valid", 32'(resp_valid), 32'd1);
    check("t1_resp_id", 32'(resp_id), 32'd2);
    tick();
    @(negedge clk);
    check("t1_resp_pulse", 32'(resp_valid), 32'd0);
    check("t1_resp_out_after", 32'(resp_out), ZERO ? 32'd0 : 32'h3);
    tick();

    // ptr is 3, only requester 1 valid: grant 1, ptr moves to 2
    req_valid = 4'b0010; req_a = 8'hE4; req_b = 8'hE4; rnd_in = 1'b1; rnd_valid = 1'b1;
    @(negedge clk);
    check("ptr_wrap_grant", 32'(req_ready), 32'h2);
    exp_q.push_back({2'd1, 1'b1});
    tick();

    // randomness missing for 3 cycles with everyone requesting
    req_valid = 4'b1111; rnd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("norand_req_ready", 32'(req_ready), 32'd0);
      check("norand_rnd_ready", 32'(rnd_ready), 32'd0);
      tick();
    end
    rnd_valid = 1'b1;
    @(negedge clk);
    check("ptr_after_wrap", 32'(req_ready), 32'h4);
    check("ptr_test_resp", 32'(resp_valid), 32'd1);
    tick();
    @(negedge clk);
    check("grant_3", 32'(req_ready), 32'h8);
    check("norand_no_resp", 32'(resp_valid), 32'd0);
    tick();

    // reset after two grants: both operations are dropped
    rst = 1'b1;
    @(negedge clk);
    check("rst_cyc_req_ready", 32'(req_ready), 32'd0);
    check("rst_cyc_rnd_ready", 32'(rnd_ready), 32'd0);
    check("rst_cyc_resp", 32'(resp_valid), 32'd0);
    tick();
    rst = 1'b0;

    // continuous requests: grants 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) begin
      req_a = 8'($urandom); req_b = 8'($urandom); rnd_in = 1'($urandom_range(0, 1));
      k = i % NREQ;
      la = req_a[k*D +: D];
      lb = req_b[k*D +: D];
      @(negedge clk);
      check("rr_grant", 32'(req_ready), 32'(1 << k));
      exp_q.push_back({IDW'(k), (la[0] ^ la[1]) & (lb[0] ^ lb[1])});
      if (i == 0) begin
        check("post_rst_g_ina", 32'(g_ina), 32'd0);
        check("post_rst_g_inb", 32'(g_inb), 32'd0);
        check("post_rst_g_rnd", 32'(g_rnd), 32'd0);
        check("post_rst_resp_out", 32'(resp_out), 32'd0);
        check("post_rst_resp_id", 32'(resp_id), 32'd0);
      end
      if (i < 4) check("post_rst_no_resp", 32'(resp_valid), 32'd0);
      if (i == 4) check("rr_first_resp", 32'(resp_valid), 32'd1);
      tick();
    end
    req_valid = '0; rnd_valid = 1'b0; req_a = '0; req_b = '0;
    repeat (8) tick();
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
